sag8: RTL and testbench

- 8-bit sheep-and-goats (SAG) bit-permutation unit, registered output.
- Bits of data word `di` whose control bit in `ci` is 1 ("sheep") are packed toward the LSB end in ascending order.
- Bits whose control bit is 0 ("goats") are packed toward the MSB end, filling downward from bit 7.
- Used as a datapath permutation primitive inside bit-manipulation/ALU logic.

---
 rtl/sag_pkg.sv | 30 +++
 rtl/sag8_if.sv | 22 ++
 rtl/sag_prefix_cnt.sv | 19 +
 rtl/sag8.sv | 63 ++++++
 tb/tb_sag8.sv | 142 ++++++++++++++
 5 files changed

// File: rtl/sag_pkg.sv
// Shared width constant and reference model for the
// 8-bit sheep-and-goats permutation.
package sag_pkg;

    localparam int SAG_W = 8;

    typedef logic [SAG_W-1:0] word_t;

    // Sequential model: sheep fill upward from bit 0,
    // goats fill downward from bit 7 (so goats end up reversed).
    function automatic word_t sag_ref(input word_t di, input word_t ci);
        word_t r;
        int    j;
        int    k;
        r = '0;
        j = 0;
        k = SAG_W - 1;
        for (int i = 0; i < SAG_W; i++) begin
            if (ci[i]) begin
                r[j] = di[i];
                j++;
            end else begin
                r[k] = di[i];
                k--;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sag8_if.sv
// Operand/result bundle for the sheep-and-goats unit.
// master drives operands, slave produces the result.
interface sag8_if;
    import sag_pkg::*;

    logic  in_valid;
    word_t di;
    word_t ci;
    logic  out_valid;
    word_t dout;

    modport master (
        output in_valid, di, ci,
        input  out_valid, dout
    );

    modport slave (
        input  in_valid, di, ci,
        output out_valid, dout
    );

endinterface

// File: rtl/sag_prefix_cnt.sv
// Prefix popcounts of the control word: s[i] counts the
// sheep strictly below bit i. Bit 7 of ci never matters.
module sag_prefix_cnt
    import sag_pkg::*;
(
    input  logic [SAG_W-2:0]      ci_i,
    output logic [SAG_W-1:0][2:0] s_o
);

    // Running sum of sheep below each bit position.
    always_comb begin
        s_o    = '0;
        s_o[0] = 3'd0;
        for (int i = 0; i < SAG_W - 1; i++) begin
            s_o[i+1] = s_o[i] + {2'b00, ci_i[i]};
        end
    end

endmodule

// File: rtl/sag8.sv
// 8-bit sheep-and-goats permutation with a single
// registered output stage (latency 1, one op per cycle).
module sag8
    import sag_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    sag8_if.slave bus
);

    logic [SAG_W-1:0][2:0]       s;
    logic [SAG_W-1:0][2:0]       dest;
    logic [SAG_W-1:0][SAG_W-1:0] sel;
    word_t                       dout_d;
    word_t                       dout_q;
    logic                        valid_q;

    sag_prefix_cnt u_cnt (
        .ci_i (bus.ci[SAG_W-2:0]),
        .s_o  (s)
    );

    // Destination of each input bit; the top bit lands on s[7]
    // whether it is a sheep or a goat, so ci[7] is not consulted.
    always_comb begin
        dest = '0;
        for (int i = 0; i < SAG_W - 1; i++) begin
            dest[i] = bus.ci[i] ? s[i]
                                : s[i] + 3'(SAG_W - 1 - i);
        end
        dest[SAG_W-1] = s[SAG_W-1];
    end

    // Scatter: each output bit ORs the inputs whose
    // destination selects it (exactly one per output).
    always_comb begin
        sel    = '0;
        dout_d = '0;
        for (int o = 0; o < SAG_W; o++) begin
            for (int i = 0; i < SAG_W; i++) begin
                sel[o][i] = (dest[i] == 3'(o));
            end
            dout_d[o] = |(sel[o] & bus.di);
        end
    end

    // Result register: capture on valid, hold data on bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            dout_q  <= '0;
        end else begin
            valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                dout_q <= dout_d;
            end
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.dout      = dout_q;

endmodule

// File: tb/tb_sag8.sv
// Scoreboard bench for sag8: stimulus queues the expected
// per-cycle output, a monitor pops and compares at negedge.
module tb_sag8;
    import sag_pkg::*;

    typedef struct packed {
        logic  v;
        word_t d;
    } exp_t;

    logic   clk;
    logic   rst;
    exp_t   q[$];
    int     checks;
    int     errors;
    word_t  held;
    logic   done;

    sag8_if bus ();

    sag8 u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expectation per clock after it was issued.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                checks++;
                if (bus.out_valid !== e.v || bus.dout !== e.d) begin
                    errors++;
                    $display("FAIL cycle: got v=%b d=%h want v=%b d=%h",
                             bus.out_valid, bus.dout, e.v, e.d);
                end
            end else if (bus.out_valid === 1'b1 && !done) begin
                checks++;
                errors++;
                $display("FAIL unexpected: out_valid=1 d=%h want none",
                         bus.dout);
            end
        end
    end

    // Drive one cycle and queue what should appear after the edge.
    task automatic issue(input logic r, input logic v,
                         input word_t d, input word_t c,
                         input word_t exp_d);
        exp_t e;
        @(negedge clk);
        #1;
        rst          = r;
        bus.in_valid = v;
        bus.di       = d;
        bus.ci       = c;
        if (r) begin
            e.v  = 1'b0;
            e.d  = 8'h00;
            held = 8'h00;
        end else if (v) begin
            e.v  = 1'b1;
            e.d  = exp_d;
            held = exp_d;
        end else begin
            e.v = 1'b0;
            e.d = held;
        end
        q.push_back(e);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        held         = 8'h00;
        done         = 1'b0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.di       = 8'h00;
        bus.ci       = 8'h00;

        // Reset overrides a valid operand
        issue(1'b1, 1'b1, 8'hFF, 8'h00, 8'h00);
        issue(1'b1, 1'b1, 8'hFF, 8'h00, 8'h00);
        issue(1'b0, 1'b0, 8'hFF, 8'h00, 8'h00);
        issue(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);

        // Identity / reverse
        issue(1'b0, 1'b1, 8'h01, 8'hFF, 8'h01);
        issue(1'b0, 1'b1, 8'h01, 8'h00, 8'h80);
        issue(1'b0, 1'b1, 8'h01, 8'h7F, 8'h01);

        // Mixed control
        issue(1'b0, 1'b1, 8'hA5, 8'h0F, 8'h55);
        issue(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        issue(1'b0, 1'b1, 8'hF0, 8'hAA, 8'h3C);
        issue(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);

        // ci[7] is a don't-care
        issue(1'b0, 1'b1, 8'hC3, 8'h00, 8'hC3);
        issue(1'b0, 1'b1, 8'hC3, 8'h80, 8'hC3);
        issue(1'b0, 1'b1, 8'hC3, 8'h01, 8'h87);
        issue(1'b0, 1'b1, 8'hC3, 8'h81, 8'h87);

        // Back-to-back stream, then bubbles holding last data
        issue(1'b0, 1'b1, 8'hA5, 8'h0F, 8'h55);
        issue(1'b0, 1'b1, 8'hF0, 8'hAA, 8'h3C);
        issue(1'b0, 1'b1, 8'h01, 8'h00, 8'h80);
        issue(1'b0, 1'b1, 8'hC3, 8'h01, 8'h87);
        issue(1'b0, 1'b0, 8'h5A, 8'hFF, 8'h00);
        issue(1'b0, 1'b0, 8'h12, 8'h34, 8'h00);

        // Exhaustive sweep against the reference model
        for (int c = 0; c < 256; c++) begin
            for (int d = 0; d < 256; d++) begin
                issue(1'b0, 1'b1, word_t'(d), word_t'(c),
                      sag_ref(word_t'(d), word_t'(c)));
            end
        end
        issue(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);

        // Drain and confirm every expectation was consumed
        @(negedge clk);
        @(negedge clk);
        done = 1'b1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending=%0d want 0", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
